// File: rtl/gray_enc_pkg.sv
// Shared types and default sizing for the Gray-coded rotary encoder tracker.
package gray_enc_pkg;

  localparam int unsigned DEF_WIDTH         = 4;
  localparam int unsigned DEF_STABLE_CYCLES = 3;
  localparam int unsigned DEF_TURN_W        = 8;

  // Tracker modes: waiting for enable, waiting for the first stable code, tracking.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2
  } state_t;

endpackage

// File: rtl/gray_enc_to_bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at and above it, which unrolls b[i] = b[i+1] ^ g[i].
module gray_to_bin_n #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // One reduction-XOR per output bit; no ripple through intermediate outputs.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_encoder_tracker.sv
// Absolute Gray encoder tracker: synchronise, debounce, convert to binary,
// classify each accepted change and keep a signed multi-turn count.
module gray_encoder_tracker
  import gray_enc_pkg::*;
#(
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned TURN_W        = DEF_TURN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clear,
  input  logic [WIDTH-1:0]  gray_in,
  output logic [WIDTH-1:0]  pos_bin,
  output logic [TURN_W-1:0] turns,
  output logic              valid,
  output logic              step_up,
  output logic              step_dn,
  output logic              err_jump
);

  localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STABLE_CYCLES);
  localparam logic [WIDTH-1:0] POS_MAX  = '1;
  localparam logic [WIDTH-1:0] POS_ONE  = WIDTH'(1);

  logic [WIDTH-1:0]  s1, s2;
  logic [CNT_W-1:0]  cnt;
  logic              stable;
  logic [WIDTH-1:0]  cand_bin;
  logic [WIDTH-1:0]  delta;
  state_t            state, next_state;
  logic [WIDTH-1:0]  pos_bin_d;
  logic [TURN_W-1:0] turns_d;
  logic              valid_d, step_up_d, step_dn_d, err_jump_d;

  // Synchroniser and debounce counter; the counter is held at zero while
  // disabled and on the IDLE->ACQUIRE edge so every acquisition sees a full window.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so s2 takes the old s1, not the new one.
    if (!rst_n) begin
      s1  <= '0;
      s2  <= '0;
      cnt <= '0;
    end else begin
      s1 <= gray_in;
      s2 <= s1;
      if (!en || state == IDLE) begin
        cnt <= '0;
      end else if (s1 != s2) begin
        cnt <= CNT_W'(1);
      end else if (cnt != CNT_FULL) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign stable = (cnt == CNT_FULL);

  gray_to_bin_n #(.WIDTH(WIDTH)) u_g2b (
    .gray (s2),
    .bin  (cand_bin)
  );

  assign delta = cand_bin - pos_bin;

  // Next-state, position, turn count and event pulses.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    next_state = state;
    pos_bin_d  = pos_bin;
    turns_d    = turns;
    valid_d    = valid;
    step_up_d  = 1'b0;
    step_dn_d  = 1'b0;
    err_jump_d = 1'b0;

    if (!en) begin
      next_state = IDLE;
      valid_d    = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          next_state = ACQUIRE;
          valid_d    = 1'b0;
        end
        ACQUIRE: begin
          if (stable) begin
            pos_bin_d  = cand_bin;
            valid_d    = 1'b1;
            next_state = TRACK;
          end
        end
        TRACK: begin
          if (stable && cand_bin != pos_bin) begin
            pos_bin_d = cand_bin;
            if (delta == POS_ONE) begin
              step_up_d = 1'b1;
              if (pos_bin == POS_MAX) turns_d = turns + TURN_W'(1);
            end else if (delta == POS_MAX) begin
              step_dn_d = 1'b1;
              if (pos_bin == '0) turns_d = turns - TURN_W'(1);
            end else begin
              err_jump_d = 1'b1;
            end
          end
        end
        default: next_state = IDLE;
      endcase
    end

    // Clearing beats a coincident wrap; the step pulse is unaffected.
    if (clear) turns_d = '0;
  end

  // State register and registered outputs, all updating on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      pos_bin  <= '0;
      turns    <= '0;
      valid    <= 1'b0;
      step_up  <= 1'b0;
      step_dn  <= 1'b0;
      err_jump <= 1'b0;
    end else begin
      state    <= next_state;
      pos_bin  <= pos_bin_d;
      turns    <= turns_d;
      valid    <= valid_d;
      step_up  <= step_up_d;
      step_dn  <= step_dn_d;
      err_jump <= err_jump_d;
    end
  end

endmodule
